avalon_mm_arbiter: RTL and testbench

AVALON_MM_ARBITER -- requirements
Module: avalon_mm_arbiter

---
 rtl/avalon_mm_arbiter.sv | 123 ++++++++++++
 tb/tb_avalon_mm_arbiter.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/avalon_mm_arbiter.sv
// Round-robin arbiter that lets NUM_MASTERS Avalon-MM masters share one slave port.
// One transaction at a time; a single IDLE arbitration cycle separates consecutive grants.
module avalon_mm_arbiter #(
    parameter int DWIDTH      = 32,
    parameter int AWIDTH      = 2,
    parameter int NUM_MASTERS = 4
) (
    input  logic                          clk_i,
    input  logic                          rst_n_i,
    input  logic [NUM_MASTERS*AWIDTH-1:0] m_address_i,
    input  logic [NUM_MASTERS-1:0]        m_write_i,
    input  logic [NUM_MASTERS*DWIDTH-1:0] m_writedata_i,
    input  logic [NUM_MASTERS-1:0]        m_read_i,
    output logic [NUM_MASTERS-1:0]        m_waitrequest_o,
    output logic [DWIDTH-1:0]             m_readdata_o,
    output logic [NUM_MASTERS-1:0]        m_readdatavalid_o,
    output logic [AWIDTH-1:0]             s_address_o,
    output logic                          s_write_o,
    output logic [DWIDTH-1:0]             s_writedata_o,
    output logic                          s_read_o,
    input  logic                          s_waitrequest_i,
    input  logic [DWIDTH-1:0]             s_readdata_i,
    input  logic                          s_readdatavalid_i
);

    localparam int GW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam logic [GW-1:0] LAST = GW'(NUM_MASTERS - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RD_WAIT = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [GW-1:0]          gnt_q, gnt_d;
    logic [GW-1:0]          rr_q, rr_d;
    logic [GW-1:0]          sel;
    logic [GW-1:0]          gnt_inc;
    logic                   found;
    logic                   wr_sel, rd_sel;
    logic [NUM_MASTERS-1:0] req;

    assign req          = m_read_i | m_write_i;
    assign gnt_inc      = (gnt_q == LAST) ? '0 : gnt_q + 1'b1;
    assign m_readdata_o = s_readdata_i;

    // First requester at or above rr_q, wrapping past the last master.
    always_comb begin
        found = 1'b0;
        sel   = rr_q;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (!found && req[(int'(rr_q) + i) % NUM_MASTERS]) begin
                found = 1'b1;
                sel   = GW'((int'(rr_q) + i) % NUM_MASTERS);
            end
        end
    end

    // NOTE: every output and next-state value gets a default before the case so no latch is inferred.
    always_comb begin
        state_d           = state_q;
        gnt_d             = gnt_q;
        rr_d              = rr_q;
        s_address_o       = '0;
        s_writedata_o     = '0;
        s_write_o         = 1'b0;
        s_read_o          = 1'b0;
        m_waitrequest_o   = '1;
        m_readdatavalid_o = '0;
        wr_sel            = m_write_i[gnt_q];
        rd_sel            = m_read_i[gnt_q] & ~wr_sel;

        case (state_q)
            IDLE: begin
                if (found) begin
                    gnt_d   = sel;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                s_address_o            = m_address_i[int'(gnt_q)*AWIDTH +: AWIDTH];
                s_writedata_o          = m_writedata_i[int'(gnt_q)*DWIDTH +: DWIDTH];
                s_write_o              = wr_sel;
                s_read_o               = rd_sel;
                m_waitrequest_o[gnt_q] = s_waitrequest_i;
                if (!wr_sel && !rd_sel) begin
                    // Master dropped its request before acceptance: give up the grant, keep priority.
                    state_d = IDLE;
                end else if (!s_waitrequest_i) begin
                    if (wr_sel) begin
                        rr_d    = gnt_inc;
                        state_d = IDLE;
                    end else begin
                        state_d = RD_WAIT;
                    end
                end
            end
            RD_WAIT: begin
                if (s_readdatavalid_i) begin
                    m_readdatavalid_o[gnt_q] = 1'b1;
                    rr_d                     = gnt_inc;
                    state_d                  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all of them update together at the edge.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            rr_q    <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            rr_q    <= rr_d;
        end
    end

endmodule

// File: tb/tb_avalon_mm_arbiter.sv
// Directed bench for avalon_mm_arbiter: write, read, stall, round-robin and reset-abort scenarios.
module tb_avalon_mm_arbiter;

    localparam int N  = 4;
    localparam int AW = 2;
    localparam int DW = 32;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N*AW-1:0] m_address;
    logic [N-1:0]    m_write;
    logic [N*DW-1:0] m_writedata;
    logic [N-1:0]    m_read;
    logic [N-1:0]    m_waitrequest;
    logic [DW-1:0]   m_readdata;
    logic [N-1:0]    m_readdatavalid;
    logic [AW-1:0]   s_address;
    logic            s_write;
    logic [DW-1:0]   s_writedata;
    logic            s_read;
    logic            s_waitrequest;
    logic [DW-1:0]   s_readdata;
    logic            s_readdatavalid;

    int checks   = 0;
    int failures = 0;

    avalon_mm_arbiter #(.DWIDTH(DW), .AWIDTH(AW), .NUM_MASTERS(N)) dut (
        .clk_i             (clk),
        .rst_n_i           (rst_n),
        .m_address_i       (m_address),
        .m_write_i         (m_write),
        .m_writedata_i     (m_writedata),
        .m_read_i          (m_read),
        .m_waitrequest_o   (m_waitrequest),
        .m_readdata_o      (m_readdata),
        .m_readdatavalid_o (m_readdatavalid),
        .s_address_o       (s_address),
        .s_write_o         (s_write),
        .s_writedata_o     (s_writedata),
        .s_read_o          (s_read),
        .s_waitrequest_i   (s_waitrequest),
        .s_readdata_i      (s_readdata),
        .s_readdatavalid_i (s_readdatavalid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "simulation did not finish");
    end

    initial begin
        logic [N-1:0] exp_wait;
        int           g;

        m_address       = '0;
        m_writedata     = '0;
        m_write         = '0;
        m_read          = '0;
        s_waitrequest   = 1'b0;
        s_readdata      = '0;
        s_readdatavalid = 1'b0;

        // Reset state
        #12;
        check("rst_s_write", s_write, 0);
        check("rst_s_read", s_read, 0);
        check("rst_waitreq", m_waitrequest, 4'hF);
        check("rst_rdv", m_readdatavalid, 0);
        check("rst_s_addr", s_address, 0);

        // Single write from m0
        @(negedge clk);
        rst_n = 1'b1;
        m_address[0*AW +: AW]   = 2'd1;
        m_writedata[0*DW +: DW] = 32'hA5A5A5A5;
        m_write[0]              = 1'b1;
        #1;
        check("wr_idle_no_strobe", s_write, 0);
        step();
        check("wr_grant_strobe", s_write, 1);
        check("wr_grant_addr", s_address, 1);
        check("wr_grant_data", s_writedata, 32'hA5A5A5A5);
        check("wr_grant_waitreq", m_waitrequest, 4'b1110);
        check("wr_grant_no_read", s_read, 0);
        step();
        m_write[0] = 1'b0;
        #1;
        check("wr_done_strobe", s_write, 0);
        check("wr_done_waitreq", m_waitrequest, 4'hF);
        check("wr_done_addr", s_address, 0);

        // Slave stall during m1 write while m0 also requests (rr_ptr = 1)
        m_write[1]              = 1'b1;
        m_address[1*AW +: AW]   = 2'd2;
        m_writedata[1*DW +: DW] = 32'hDEADBEEF;
        m_write[0]              = 1'b1;
        m_address[0*AW +: AW]   = 2'd0;
        m_writedata[0*DW +: DW] = 32'h0000_0011;
        s_waitrequest           = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check("stall_strobe", s_write, 1);
            check("stall_addr", s_address, 2);
            check("stall_data", s_writedata, 32'hDEADBEEF);
            check("stall_waitreq", m_waitrequest, 4'hF);
        end
        step();
        s_waitrequest = 1'b0;
        #1;
        check("stall_release_waitreq", m_waitrequest, 4'b1101);
        check("stall_release_strobe", s_write, 1);
        step();
        m_write[1] = 1'b0;
        #1;
        check("stall_after_strobe", s_write, 0);
        check("stall_after_waitreq", m_waitrequest, 4'hF);
        step();
        check("m0_after_m1_addr", s_address, 0);
        check("m0_after_m1_data", s_writedata, 32'h0000_0011);
        check("m0_after_m1_waitreq", m_waitrequest, 4'b1110);
        step();
        m_write[0] = 1'b0;
        #1;
        check("m0_done_strobe", s_write, 0);

        // Read from m2 with latency (rr_ptr = 1)
        m_read[2]             = 1'b1;
        m_address[2*AW +: AW] = 2'd3;
        #1;
        check("rd_idle_no_strobe", s_read, 0);
        step();
        check("rd_grant_strobe", s_read, 1);
        check("rd_grant_addr", s_address, 3);
        check("rd_grant_waitreq", m_waitrequest, 4'b1011);
        check("rd_grant_no_write", s_write, 0);
        step();
        m_read[2] = 1'b0;
        #1;
        check("rd_wait_strobe", s_read, 0);
        check("rd_wait_waitreq", m_waitrequest, 4'hF);
        check("rd_wait_rdv0", m_readdatavalid, 0);
        step();
        check("rd_wait_rdv1", m_readdatavalid, 0);
        step();
        s_readdata      = 32'h12345678;
        s_readdatavalid = 1'b1;
        #1;
        check("rd_rdv_pulse", m_readdatavalid, 4'b0100);
        check("rd_readdata", m_readdata, 32'h12345678);
        step();
        s_readdatavalid = 1'b0;
        #1;
        check("rd_rdv_cleared", m_readdatavalid, 0);
        s_readdatavalid = 1'b1;
        #1;
        check("rdv_ignored_in_idle", m_readdatavalid, 0);
        s_readdatavalid = 1'b0;

        // m3 drives read and write together (rr_ptr = 3): write wins
        m_write[3]              = 1'b1;
        m_read[3]               = 1'b1;
        m_address[3*AW +: AW]   = 2'd1;
        m_writedata[3*DW +: DW] = 32'hCAFEF00D;
        step();
        check("rw_write_wins", s_write, 1);
        check("rw_no_read", s_read, 0);
        check("rw_data", s_writedata, 32'hCAFEF00D);
        check("rw_waitreq", m_waitrequest, 4'b0111);
        step();
        m_write[3] = 1'b0;
        #1;
        check("rw_idle_write", s_write, 0);
        check("rw_idle_read", s_read, 0);
        step();
        check("rw_read_later", s_read, 1);
        check("rw_read_no_write", s_write, 0);
        check("rw_read_addr", s_address, 1);
        step();
        m_read[3] = 1'b0;
        #1;
        check("rw_rdwait_strobe", s_read, 0);

        // Reset while in RD_WAIT, then the slave answers
        rst_n           = 1'b0;
        s_readdata      = 32'hBAD0BAD0;
        s_readdatavalid = 1'b1;
        #1;
        check("abort_rdv_in_reset", m_readdatavalid, 0);
        check("abort_waitreq_in_reset", m_waitrequest, 4'hF);
        check("abort_read_in_reset", s_read, 0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check("abort_rdv_after_reset", m_readdatavalid, 0);
        check("abort_idle_waitreq", m_waitrequest, 4'hF);
        s_readdatavalid = 1'b0;

        // Round-robin: all masters write continuously from rr_ptr = 0
        for (int k = 0; k < N; k++) begin
            m_address[k*AW +: AW]   = AW'(k);
            m_writedata[k*DW +: DW] = 32'h0000_1000 + 32'(k);
        end
        m_write = 4'hF;
        #1;
        check("rr_idle_no_strobe", s_write, 0);
        for (int j = 0; j < 5; j++) begin
            g        = j % N;
            exp_wait = 4'hF;
            exp_wait[g] = 1'b0;
            step();
            check("rr_grant_addr", s_address, 64'(g));
            check("rr_grant_data", s_writedata, 64'(32'h0000_1000 + 32'(g)));
            check("rr_grant_waitreq", m_waitrequest, exp_wait);
            step();
            check("rr_gap_strobe", s_write, 0);
        end
        m_write = '0;
        step();
        check("rr_end_strobe", s_write, 0);
        check("rr_end_waitreq", m_waitrequest, 4'hF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
